// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment display blocks.
//   SEG_BLANK  - active-low pattern with every segment off
//   hex_to_seg - 4-bit hex digit to active-low segments (bit 0 = A .. bit 6 = G)
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex digit to active-low seven-segment decoder.
//   hexIn  - 4-bit digit value
//   segOut - active-low segments, bit 0 = A .. bit 6 = G
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hexIn,
    output logic [6:0] segOut
);

    assign segOut = hex_to_seg(hexIn);

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed hex driver for common-anode digits.
//   clkIn, rstIn        - clock, synchronous active-high reset
//   loadIn              - strobe capturing valueIn/dpIn (applied at next frame boundary)
//   valueIn, dpIn       - one nibble / decimal point per digit, digit 0 rightmost
//   enIn                - 0 darkens the display, scanning continues
//   segOut, decimalOut  - active-low segments and decimal point of the scanned digit
//   anodeOut            - active-low digit select, at most one bit low
//   frameOut            - one-cycle pulse after the scan wraps to digit 0
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 100000,
    parameter int GUARD_CYCLES  = 2,
    parameter int LEADING_BLANK = 1
) (
    input  logic                    clkIn,
    input  logic                    rstIn,
    input  logic                    loadIn,
    input  logic [4*NUM_DIGITS-1:0] valueIn,
    input  logic [NUM_DIGITS-1:0]   dpIn,
    input  logic                    enIn,
    output logic [6:0]              segOut,
    output logic                    decimalOut,
    output logic [NUM_DIGITS-1:0]   anodeOut,
    output logic                    frameOut
);

    localparam int DIV_W = $clog2(REFRESH_DIV + 1);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    logic [DIV_W-1:0]                divCnt;
    logic [IDX_W-1:0]                digitIdx;
    logic [VAL_W-1:0]                dispVal, pendVal;
    logic [NUM_DIGITS-1:0]           dispDp, pendDp;
    logic                            pendValid;
    logic                            tick, frameEdge, lit;
    logic [NUM_DIGITS-1:0][6:0]      decSeg, digSeg;

    assign tick      = (divCnt == DIV_W'(REFRESH_DIV - 1));
    assign frameEdge = tick && (digitIdx == IDX_W'(NUM_DIGITS - 1));
    // Guard interval at slot start keeps the previous digit's segments from
    // ghosting onto the newly selected anode.
    assign lit       = enIn && (divCnt >= DIV_W'(GUARD_CYCLES));

    // One decoder per digit; blanking is a pure function of the display
    // register, so the scan just selects the finished pattern.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
        seg_hex_decode uDec (
            .hexIn  (dispVal[4*i +: 4]),
            .segOut (decSeg[i])
        );
        if (i == 0 || LEADING_BLANK == 0) begin : gNoBlank
            assign digSeg[i] = decSeg[i];
        end else begin : gBlank
            // Blank when this digit and every more-significant digit is zero.
            assign digSeg[i] = (dispVal[VAL_W-1:4*i] == '0) ? SEG_BLANK : decSeg[i];
        end
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            divCnt     <= '0;
            digitIdx   <= '0;
            dispVal    <= '0;
            dispDp     <= '0;
            pendVal    <= '0;
            pendDp     <= '0;
            pendValid  <= 1'b0;
            segOut     <= SEG_BLANK;
            decimalOut <= 1'b1;
            anodeOut   <= '1;
            frameOut   <= 1'b0;
        end else begin
            divCnt <= tick ? '0 : divCnt + 1'b1;
            if (tick)
                digitIdx <= frameEdge ? '0 : digitIdx + 1'b1;
            frameOut <= frameEdge;

            // Display registers only change at a frame boundary so a frame
            // never mixes old and new digits. A load landing on the boundary
            // itself wins over anything still pending.
            if (frameEdge) begin
                if (loadIn) begin
                    dispVal <= valueIn;
                    dispDp  <= dpIn;
                end else if (pendValid) begin
                    dispVal <= pendVal;
                    dispDp  <= pendDp;
                end
                pendValid <= 1'b0;
            end else if (loadIn) begin
                pendVal   <= valueIn;
                pendDp    <= dpIn;
                pendValid <= 1'b1;
            end

            if (lit) begin
                anodeOut   <= ~(NUM_DIGITS'(1) << digitIdx);
                segOut     <= digSeg[digitIdx];
                decimalOut <= ~dispDp[digitIdx];
            end else begin
                anodeOut   <= '1;
                segOut     <= SEG_BLANK;
                decimalOut <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: randomized and directed stimulus against a cycle-count
// based reference model; two DUTs (leading blank on / off) share the inputs.
module tb_seg_scan_display;

    localparam int N = 4;
    localparam int R = 8;
    localparam int G = 2;
    localparam int FRAME = N * R;

    logic        clkIn = 1'b0;
    logic        rstIn, loadIn, enIn;
    logic [15:0] valueIn;
    logic [3:0]  dpIn;
    logic [6:0]  segA, segB;
    logic        decA, decB, frA, frB;
    logic [3:0]  anA, anB;

    always #5 clkIn = ~clkIn;

    seg_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .LEADING_BLANK(1)) dutA (
        .clkIn(clkIn), .rstIn(rstIn), .loadIn(loadIn), .valueIn(valueIn), .dpIn(dpIn), .enIn(enIn),
        .segOut(segA), .decimalOut(decA), .anodeOut(anA), .frameOut(frA));

    seg_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GUARD_CYCLES(G), .LEADING_BLANK(0)) dutB (
        .clkIn(clkIn), .rstIn(rstIn), .loadIn(loadIn), .valueIn(valueIn), .dpIn(dpIn), .enIn(enIn),
        .segOut(segB), .decimalOut(decB), .anodeOut(anB), .frameOut(frB));

    logic [6:0] segTbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: time since reset, visible value, pending value.
    int          k = 0;
    int          cyc = 0;
    int          lastFrame = -1;
    logic [15:0] mVal = '0, pVal = '0;
    logic [3:0]  mDp = '0, pDp = '0;
    bit          pV = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] expSeg(input logic [15:0] v, input int dig, input bit lb);
        logic [15:0] upper;
        upper = v >> (4 * dig);
        if (lb && dig > 0 && upper == 16'h0)
            return 7'h7F;
        return segTbl[upper[3:0]];
    endfunction

    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] d,
                        input logic e, input logic r);
        logic [6:0] eSegA, eSegB;
        logic       eDec, eFr;
        logic [3:0] eAn;
        int         slot, dig;
        bit         boundary;
        rstIn = r; loadIn = ld; valueIn = v; dpIn = d; enIn = e;
        @(posedge clkIn);
        cyc++;
        eSegA = 7'h7F; eSegB = 7'h7F; eDec = 1'b1; eAn = 4'hF; eFr = 1'b0;
        if (r) begin
            k = 0; mVal = '0; mDp = '0; pVal = '0; pDp = '0; pV = 0; lastFrame = -1;
        end else begin
            slot     = k % R;
            dig      = (k / R) % N;
            boundary = (k % FRAME) == FRAME - 1;
            if (e && slot >= G) begin
                eAn   = ~(4'b0001 << dig);
                eSegA = expSeg(mVal, dig, 1'b1);
                eSegB = expSeg(mVal, dig, 1'b0);
                eDec  = ~mDp[dig];
            end
            eFr = boundary;
            if (boundary) begin
                if (ld) begin mVal = v; mDp = d; end
                else if (pV) begin mVal = pVal; mDp = pDp; end
                pV = 0;
            end else if (ld) begin
                pVal = v; pDp = d; pV = 1;
            end
            k++;
        end
        #1;
        check("segOut", {25'd0, segA}, {25'd0, eSegA});
        check("decimalOut", {31'd0, decA}, {31'd0, eDec});
        check("anodeOut", {28'd0, anA}, {28'd0, eAn});
        check("frameOut", {31'd0, frA}, {31'd0, eFr});
        check("segOut noBlank", {25'd0, segB}, {25'd0, eSegB});
        if (frA === 1'b1 && !r) begin
            if (lastFrame >= 0)
                check("framePeriod", cyc - lastFrame, FRAME);
            lastFrame = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, 1'b1, 1'b0);
    endtask

    // Step until the model's state sits at frame position pos (bounded).
    task automatic seekPos(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) idle(1);
    endtask

    // Wait for a frame pulse, then check one full frame of digits against
    // literal patterns (digit 3 in the top 7 bits, digit 0 in the bottom).
    task automatic spotFrame(input logic [27:0] expA, input logic [27:0] expB, input logic [3:0] expDp);
        int  n;
        bit  seen;
        seen = 0;
        for (n = 0; n < 3 * FRAME && !seen; n++) begin
            idle(1);
            seen = (frA === 1'b1);
        end
        if (!seen) check("frameTimeout", 32'd0, 32'd1);
        for (int c = 0; c < FRAME; c++) begin
            idle(1);
            for (int i = 0; i < N; i++) begin
                if (anA == ~(4'b0001 << i)) begin
                    check("spotSegA", {25'd0, segA}, {25'd0, expA[7*i +: 7]});
                    check("spotSegB", {25'd0, segB}, {25'd0, expB[7*i +: 7]});
                    check("spotDp", {31'd0, decA}, {31'd0, ~expDp[i]});
                end
            end
        end
    endtask

    initial begin
        logic [15:0] masks [5];
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};

        // Reset held, with inputs trying to disturb it.
        for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b1);

        // Anode timing right after reset release.
        for (int e = 1; e <= 16; e++) begin
            idle(1);
            if (e >= 3 && e <= 8)   check("rstAnodeD0", {28'd0, anA}, 32'hE);
            if (e == 9)             check("rstAnodeGuard", {28'd0, anA}, 32'hF);
            if (e >= 11 && e <= 16) check("rstAnodeD1", {28'd0, anA}, 32'hD);
        end

        step(1'b1, 16'h1234, 4'b0010, 1'b1, 1'b0);
        spotFrame({7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0010);

        step(1'b1, 16'h0070, 4'b0000, 1'b1, 1'b0);
        spotFrame({7'h7F, 7'h7F, 7'h78, 7'h40}, {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0000);

        step(1'b1, 16'h0000, 4'b1000, 1'b1, 1'b0);
        spotFrame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1000);

        // Two loads within one frame: old value stays until the boundary.
        seekPos(10);
        step(1'b1, 16'hAAAA, 4'b0000, 1'b1, 1'b0);
        idle(5);
        step(1'b1, 16'hBBBB, 4'b0000, 1'b1, 1'b0);
        spotFrame({4{7'h03}}, {4{7'h03}}, 4'b0000);

        // Load on the boundary cycle beats an older pending value.
        seekPos(5);
        step(1'b1, 16'h1111, 4'b1111, 1'b1, 1'b0);
        seekPos(FRAME - 1);
        step(1'b1, 16'hC0DE, 4'b0000, 1'b1, 1'b0);
        check("coincidentFrame", {31'd0, frA}, 32'd1);
        for (int c = 0; c < FRAME; c++) begin
            idle(1);
            if (anA == 4'b0111) check("coincidentD3", {25'd0, segA}, 32'h46);
            if (anA == 4'b1011) check("coincidentD2", {25'd0, segA}, 32'h40);
        end

        // Reset mid-frame with something pending.
        seekPos(12);
        step(1'b1, 16'h5555, 4'b1111, 1'b1, 1'b0);
        idle(3);
        step(1'b0, 16'h0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 4'h0, 1'b1, 1'b1);
        spotFrame({7'h7F, 7'h7F, 7'h7F, 7'h40}, {4{7'h40}}, 4'b0000);

        // Display dark; scanning and frame cadence continue.
        step(1'b1, 16'h8888, 4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 16'h0, 4'h0, 1'b0, 1'b0);
        idle(10);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic        ld, en, rs;
            logic [15:0] v;
            ld = ($urandom % 12) == 0;
            v  = 16'($urandom) & masks[$urandom % 5];
            en = ($urandom % 16) != 0;
            rs = ($urandom % 300) == 0;
            step(ld, v, 4'($urandom), en, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
